// File: rtl/unidade_muldiv_if.sv
// unidade_muldiv_if: request/response bundle of the RV32M multiply/divide unit.
// The master drives the request side; the slave (the unit) drives the response.
interface unidade_muldiv_if;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [4:0]  rd_in;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic [4:0]  rd_out;
  logic        reg_write;

  modport master (
    output start,
    output funct3,
    output op_a,
    output op_b,
    output rd_in,
    output flush,
    input  busy,
    input  done,
    input  result,
    input  rd_out,
    input  reg_write
  );

  modport slave (
    input  start,
    input  funct3,
    input  op_a,
    input  op_b,
    input  rd_in,
    input  flush,
    output busy,
    output done,
    output result,
    output rd_out,
    output reg_write
  );
endinterface

// File: rtl/unidade_muldiv.sv
// unidade_muldiv: iterative RV32M multiply/divide unit.
// Shift-add multiply and restoring divide on magnitudes, signs fixed at the end.
module unidade_muldiv (
  input logic               clk,
  input logic               rst_n,
  unidade_muldiv_if.slave   bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]  r_state;
  logic [4:0]  r_cnt;
  logic [2:0]  r_f3;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [31:0] r_mag;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic        r_sa;
  logic        r_sb;
  logic [4:0]  r_rd_in;
  logic [4:0]  r_rd;
  logic [31:0] r_result;
  logic        r_done;

  function automatic logic f_a_signed(
    input logic [2:0] f
  );
    return f[2] ? ~f[0] : (f[1:0] != 2'b11);
  endfunction

  function automatic logic f_b_signed(
    input logic [2:0] f
  );
    return f[2] ? ~f[0] : ~f[1];
  endfunction

  logic        w_sa;
  logic        w_sb;
  logic [31:0] w_mag_a;
  logic [31:0] w_mag_b;

  assign w_sa = bus.op_a[31]
              & f_a_signed(bus.funct3);
  assign w_sb = bus.op_b[31]
              & f_b_signed(bus.funct3);
  assign w_mag_a = w_sa ? (~bus.op_a + 32'd1)
                        : bus.op_a;
  assign w_mag_b = w_sb ? (~bus.op_b + 32'd1)
                        : bus.op_b;

  // multiply step: {hi,lo} holds partial product and remaining multiplier
  logic [32:0] w_sum;
  logic [31:0] w_addend;

  assign w_addend = r_lo[0] ? r_mag : 32'd0;
  assign w_sum    = {1'b0, r_hi}
                  + {1'b0, w_addend};

  // divide step: hi is partial remainder, lo shifts dividend out, quotient in
  logic [32:0] w_sh;
  logic [32:0] w_diff;
  logic        w_fits;

  assign w_sh   = {r_hi, r_lo[31]};
  assign w_diff = w_sh - {1'b0, r_mag};
  assign w_fits = ~w_diff[32];

  logic        w_neg;
  logic [63:0] w_prod;
  logic [63:0] w_prod_s;
  logic [31:0] w_quo_s;
  logic [31:0] w_rem_s;
  logic        w_bz;
  logic [31:0] w_res;

  assign w_neg    = r_sa ^ r_sb;
  assign w_prod   = {r_hi, r_lo};
  assign w_prod_s = w_neg ? (~w_prod + 64'd1)
                          : w_prod;
  assign w_quo_s  = w_neg ? (~r_lo + 32'd1)
                          : r_lo;
  assign w_rem_s  = r_sa ? (~r_hi + 32'd1)
                         : r_hi;
  assign w_bz     = (r_b == 32'd0);

  always_comb begin
    w_res = w_prod_s[31:0];
    unique case (1'b1)
      (r_f3 == 3'b000):
        w_res = w_prod_s[31:0];
      (!r_f3[2] && r_f3 != 3'b000):
        w_res = w_prod_s[63:32];
      (r_f3[2] && !r_f3[1]):
        w_res = w_bz ? 32'hFFFF_FFFF
                     : w_quo_s;
      (r_f3[2] && r_f3[1]):
        w_res = w_bz ? r_a : w_rem_s;
      default:
        w_res = w_prod_s[31:0];
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_cnt    <= 5'd0;
      r_f3     <= 3'd0;
      r_a      <= 32'd0;
      r_b      <= 32'd0;
      r_mag    <= 32'd0;
      r_hi     <= 32'd0;
      r_lo     <= 32'd0;
      r_sa     <= 1'b0;
      r_sb     <= 1'b0;
      r_rd_in  <= 5'd0;
      r_rd     <= 5'd0;
      r_result <= 32'd0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (bus.flush) begin
        r_state <= IDLE;
      end else begin
        case (r_state)
          IDLE: begin
            // done still showing means busy is high
            if (bus.start && !r_done) begin
              r_f3    <= bus.funct3;
              r_a     <= bus.op_a;
              r_b     <= bus.op_b;
              r_rd_in <= bus.rd_in;
              r_sa    <= w_sa;
              r_sb    <= w_sb;
              r_hi    <= 32'd0;
              r_cnt   <= 5'd31;
              r_state <= CALC;
              if (bus.funct3[2]) begin
                r_lo  <= w_mag_a;
                r_mag <= w_mag_b;
              end else begin
                r_lo  <= w_mag_b;
                r_mag <= w_mag_a;
              end
            end
          end
          CALC: begin
            if (r_f3[2]) begin
              r_hi <= w_fits ? w_diff[31:0]
                             : w_sh[31:0];
              r_lo <= {r_lo[30:0], w_fits};
            end else begin
              r_hi <= w_sum[32:1];
              r_lo <= {w_sum[0], r_lo[31:1]};
            end
            r_cnt <= r_cnt - 5'd1;
            if (r_cnt == 5'd0)
              r_state <= FIX;
          end
          FIX: begin
            r_result <= w_res;
            r_rd     <= r_rd_in;
            r_state  <= DONE;
          end
          DONE: begin
            r_done  <= 1'b1;
            r_state <= IDLE;
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign bus.busy      = (r_state != IDLE)
                       | r_done;
  assign bus.done      = r_done;
  assign bus.reg_write = r_done;
  assign bus.result    = r_result;
  assign bus.rd_out    = r_rd;

endmodule
